// File: rtl/idx_delay_line_pkg.sv
// idx_delay_pkg: shared FSM type, default sizes and delay clamping for idx_delay_line.
`ifndef D_width
`define D_width 8
`endif
package idx_delay_pkg;
   typedef enum logic {IDLE, ACTIVE} state_e;
   localparam int CH_DEF = 32;
   localparam int MAX_DELAY_DEF = 16;
   function automatic int clamp_delay(input int d, input int max_d);
      return (d < 1) ? 1 : (d > max_d) ? max_d : d;
   endfunction
endpackage

// File: rtl/idx_delay_line_stage.sv
// delay_stage: one enabled pipeline register with asynchronous active-low clear.
module delay_stage #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (en) q <= d;
endmodule

// File: rtl/idx_delay_line.sv
// idx_delay_line: programmable-tap delay line for butterfly MA/BN indices and their valid tag,
// with stall, flush, occupancy tracking and an end-of-stream done pulse.
module idx_delay_line
   import idx_delay_pkg::*;
#(
   parameter int DW        = `D_width,
   parameter int CH        = CH_DEF,
   parameter int MAX_DELAY = MAX_DELAY_DEF,
   parameter int DLW       = $clog2(MAX_DELAY + 1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [DLW-1:0] cfg_delay,
   input  logic           in_valid,
   input  logic [CH*DW-1:0] in_idx,
   input  logic           stall,
   input  logic           flush,
   output logic           out_valid,
   output logic [CH*DW-1:0] out_idx,
   output logic           done,
   output logic           busy
);
   localparam int W = CH * DW + 1;
   logic [W-1:0]   stg [0:MAX_DELAY];
   logic [W-1:0]   nxt [1:MAX_DELAY];
   logic [W-1:0]   tap;
   logic [DLW-1:0] act_delay;
   logic [DLW-1:0] occ;
   logic           acc, ret, done_d;
   state_e         state_q, state_d;
   assign stg[0] = {in_valid, in_idx};
   // Entries passing beyond the tap lose their valid bit so a later, deeper tap never sees them.
   for (genvar j = 1; j <= MAX_DELAY; j++) begin : g_stg
      assign nxt[j] = flush ? '0 : {stg[j-1][W-1] & (DLW'(j) <= act_delay), stg[j-1][W-2:0]};
      delay_stage #(.W(W)) u_stage (
         .clk  (clk),
         .rst_n(rst_n),
         .en   (flush | ~stall),
         .d    (nxt[j]),
         .q    (stg[j])
      );
   end
   assign tap       = stg[act_delay];
   assign out_valid = tap[W-1];
   assign out_idx   = tap[W-2:0];
   assign busy      = state_q == ACTIVE;
   assign acc       = in_valid & ~stall & ~flush;
   assign ret       = out_valid & ~stall & ~flush;
   always_comb begin
      done_d  = state_q == ACTIVE && occ == DLW'(1) && ret && !acc;
      state_d = flush ? IDLE : (state_q == IDLE) ? (acc ? ACTIVE : IDLE) : (done_d ? IDLE : ACTIVE);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= IDLE;
         occ       <= '0;
         done      <= 1'b0;
         act_delay <= DLW'(MAX_DELAY);
      end else begin
         state_q <= state_d;
         done    <= done_d;
         occ     <= flush ? '0 : occ + DLW'(acc) - DLW'(ret);
         if (state_q == IDLE) act_delay <= DLW'(clamp_delay(int'(cfg_delay), MAX_DELAY));
      end
endmodule

// File: tb/tb_idx_delay_line.sv
// tb_idx_delay_line: directed streams with a latency/data scoreboard for idx_delay_line.
module tb_idx_delay_line;
   localparam int DW = 8, CH = 4, DLW = 5, IW = CH * DW;
   logic           clk = 0, rst_n = 1, in_valid = 0, stall = 0, flush = 0;
   logic [DLW-1:0] cfg_delay = '0;
   logic [IW-1:0]  in_idx = '0, out_idx;
   logic           out_valid, done, busy;
   int checks = 0, failures = 0, en_cnt = 0, done_cnt = 0, exp_d = 1, d0;
   typedef struct {int at; logic [IW-1:0] d;} ent_t;
   ent_t q[$];
   ent_t e;
   logic prev_stall = 0, prev_valid = 0;
   logic [IW-1:0] prev_idx = '0;

   always #5 clk = ~clk;

   idx_delay_line #(.DW(DW), .CH(CH), .MAX_DELAY(16)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_delay(cfg_delay), .in_valid(in_valid), .in_idx(in_idx),
      .stall(stall), .flush(flush), .out_valid(out_valid), .out_idx(out_idx), .done(done), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [IW-1:0] pat(input int base);
      logic [IW-1:0] v;
      for (int k = 0; k < CH; k++) v[k*DW +: DW] = DW'(base + k);
      return v;
   endfunction

   // Scoreboard: en_cnt counts non-stalled edges, so stalls stretch latency one cycle each.
   always @(negedge clk) begin
      if (!rst_n || flush) q.delete();
      else begin
         if (prev_stall) begin
            chk("stall_frozen_valid", out_valid, prev_valid);
            chk("stall_frozen_idx", out_idx, prev_idx);
         end
         if (out_valid && !stall) begin
            if (q.size() == 0) chk("unexpected_valid", out_valid, 0);
            else begin
               e = q.pop_front();
               chk("out_idx", out_idx, e.d);
               chk("latency", en_cnt, e.at);
            end
         end
         if (in_valid && !stall) q.push_back('{en_cnt + exp_d, in_idx});
         if (!stall) en_cnt++;
      end
      if (done) done_cnt++;
      prev_stall = rst_n && stall && !flush;
      prev_valid = out_valid;
      prev_idx   = out_idx;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         in_valid = 1;
         in_idx   = pat(base + i);
         tick();
      end
      in_valid = 0;
   endtask

   task automatic wait_done(input string tag);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!done && t < 200);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_low"}, busy, 0);
      tick();
      chk({tag, "_done_one_cycle"}, done, 0);
      chk({tag, "_done_count"}, done_cnt - d0, 1);
      chk({tag, "_drained"}, q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      #1 rst_n = 0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      tick();
      tick();
      rst_n = 1;
      // single beat at delay 12
      cfg_delay = 12; exp_d = 12; tick();
      d0 = done_cnt;
      send(1, 1);
      chk("t1_busy", busy, 1);
      chk("t1_no_early_valid", out_valid, 0);
      wait_done("t1");
      // delay 1 burst
      cfg_delay = 1; exp_d = 1; tick();
      d0 = done_cnt;
      send(20, 20);
      chk("t2_busy", busy, 1);
      wait_done("t2");
      // delay 5 burst with 3 stall cycles mid-stream
      cfg_delay = 5; exp_d = 5; tick();
      d0 = done_cnt;
      send(6, 50);
      in_valid = 1; in_idx = pat(56); stall = 1;
      repeat (3) tick();
      chk("t3_busy_stall", busy, 1);
      stall = 0;
      tick();
      send(1, 57);
      wait_done("t3");
      // cfg change while busy is ignored until the next stream
      cfg_delay = 4; exp_d = 4; tick();
      d0 = done_cnt;
      send(6, 70);
      cfg_delay = 9;
      wait_done("t4a");
      exp_d = 9; tick();
      d0 = done_cnt;
      send(3, 80);
      wait_done("t4b");
      // clamping of 0 and of values above MAX_DELAY
      cfg_delay = 0; exp_d = 1; tick();
      d0 = done_cnt;
      send(2, 90);
      wait_done("t5_lo");
      cfg_delay = 31; exp_d = 16; tick();
      d0 = done_cnt;
      send(2, 95);
      wait_done("t5_hi");
      // flush with 6 entries in flight; a same-cycle in_valid is dropped
      cfg_delay = 10; exp_d = 10; tick();
      d0 = done_cnt;
      send(6, 100);
      flush = 1; in_valid = 1; in_idx = pat(200);
      tick();
      flush = 0; in_valid = 0;
      chk("t6_flush_valid", out_valid, 0);
      chk("t6_flush_busy", busy, 0);
      repeat (20) tick();
      chk("t6_flush_no_done", done_cnt - d0, 0);
      // reset mid-stream
      tick();
      d0 = done_cnt;
      send(6, 120);
      rst_n = 0;
      #1;
      chk("t7_rst_valid", out_valid, 0);
      chk("t7_rst_idx", out_idx, 0);
      chk("t7_rst_busy", busy, 0);
      chk("t7_rst_done", done, 0);
      tick();
      rst_n = 1;
      repeat (20) tick();
      chk("t7_rst_no_done", done_cnt - d0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
